// File: rtl/corescore_arb_pkg.sv
// Shared definitions for the CoreScore stream arbiter: FSM encoding and
// pointer-width helper used by the top and the round-robin picker.
package corescore_arb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Width of a source index; never less than one bit.
  function automatic int ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/corescore_rr_pick.sv
// Combinational round-robin picker: first requester strictly after the
// pointer, searching upward with wrap-around.
module corescore_rr_pick
  import corescore_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  logic found;
  int   cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = |req_i;
    found   = 1'b0;
    cand    = 0;
    // Offset N wraps back to the pointer itself, so the last owner is
    // considered only after every other source.
    for (int off = 1; off <= N; off++) begin
      cand = (int'(ptr_i) + off) % N;
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/corescore_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one byte-wide UART transmit
// sink between several tdata/tlast/tvalid/tready emitters.
module corescore_stream_arbiter
  import corescore_arb_pkg::*;
#(
  parameter int NUM_SOURCES = 4,
  parameter int MAX_BYTES   = 0,
  parameter int CNT_W       = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [8*NUM_SOURCES-1:0] i_tdata,
  input  logic [NUM_SOURCES-1:0]   i_tlast,
  input  logic [NUM_SOURCES-1:0]   i_tvalid,
  output logic [NUM_SOURCES-1:0]   o_tready,
  input  logic                     i_sink_ena,
  output logic [7:0]               o_sink_dat,
  output logic                     o_sink_val,
  output logic [NUM_SOURCES-1:0]   o_grant,
  output logic                     o_busy,
  output logic                     o_forced
);

  localparam int PW = ptr_w(NUM_SOURCES);

  arb_state_e             state_q, state_d;
  logic [NUM_SOURCES-1:0] grant_q, grant_d;
  logic [PW-1:0]          gidx_q, gidx_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [7:0]             dat_q, dat_d;
  logic                   val_q, val_d;
  logic                   forced_q, forced_d;

  logic [NUM_SOURCES-1:0] pick_grant;
  logic [PW-1:0]          pick_idx;
  logic                   pick_any;

  corescore_rr_pick #(
    .N  (NUM_SOURCES),
    .PW (PW)
  ) u_pick (
    .req_i   (i_tvalid),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  logic             sel_valid;
  logic             sel_last;
  logic [7:0]       sel_data;
  logic [CNT_W:0]   count_inc;
  logic             limit_hit;
  logic             accept;

  assign sel_valid = i_tvalid[gidx_q];
  assign sel_last  = i_tlast[gidx_q];
  assign sel_data  = i_tdata[{gidx_q, 3'b000} +: 8];
  assign count_inc = {1'b0, count_q} + 1'b1;
  assign limit_hit = (MAX_BYTES != 0) && (count_inc == (CNT_W+1)'(MAX_BYTES));

  // Blocking on val_q leaves the sink its one-cycle gap after every push.
  assign accept   = (state_q == ST_LOCKED) && sel_valid && i_sink_ena && !val_q;
  assign o_tready = accept ? grant_q : '0;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    ptr_d    = ptr_q;
    count_d  = count_q;
    dat_d    = dat_q;
    val_d    = 1'b0;
    forced_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_LOCKED;
          grant_d = pick_grant;
          gidx_d  = pick_idx;
          count_d = '0;
        end
      end
      ST_LOCKED: begin
        if (accept) begin
          dat_d   = sel_data;
          val_d   = 1'b1;
          count_d = (&count_q) ? count_q : count_inc[CNT_W-1:0];
          // tlast wins over the byte limit, so forced only flags a cut packet.
          if (sel_last || limit_hit) begin
            state_d  = ST_IDLE;
            grant_d  = '0;
            ptr_d    = gidx_q;
            forced_d = !sel_last;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      ptr_q    <= PW'(NUM_SOURCES - 1);
      count_q  <= '0;
      dat_q    <= '0;
      val_q    <= 1'b0;
      forced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      ptr_q    <= ptr_d;
      count_q  <= count_d;
      dat_q    <= dat_d;
      val_q    <= val_d;
      forced_q <= forced_d;
    end
  end

  assign o_sink_dat = dat_q;
  assign o_sink_val = val_q;
  assign o_grant    = grant_q;
  assign o_busy     = (state_q == ST_LOCKED);
  assign o_forced   = forced_q;

endmodule
